// File: rtl/pwm_ramp_gen.sv
// -----------------------------------------------------------------------------
// pwm_ramp_gen
//
// Purpose
//   Soft-start duty generator for a downstream timer/PWM block. While enabled,
//   the compare value walks toward a live target by a programmable step. One
//   update happens every (interval + 1) clock cycles. When the compare reaches
//   the target, the FSM parks in HOLD and pulses done for one cycle. If the
//   target moves away again, the FSM re-enters RAMP.
//
// Build option
//   PWM_RAMP_DOWN_EN  defined   : dropping enable in RAMP/HOLD enters DOWN.
//                                 DOWN soft-ramps compare to 0, then goes to IDLE.
//                     undefined : dropping enable releases at once. The next
//                                 cycle is IDLE with compare = 0. No DOWN state
//                                 is built.
//
// Ports
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous, active-high reset
//   i_enable    in   1  high = drive toward target, low = release
//   i_target    in  32  requested compare value, sampled live at updates
//   i_step      in  32  increment/decrement per update (0 = jump to target)
//   i_interval  in  32  update spacing minus one, in clk cycles
//   o_compare   out 32  duty compare value for the downstream timer
//   o_control   out  2  2'b10 (PWM) whenever state != IDLE, else 2'b00
//   o_busy      out  1  high while ramping (RAMP, and DOWN when built)
//   o_done      out  1  one-cycle pulse when compare first equals target
//
// All outputs come straight from registers. No input reaches an output
// without passing through a flop.
// -----------------------------------------------------------------------------
module pwm_ramp_gen (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_enable,
   input  logic [31:0] i_target,
   input  logic [31:0] i_step,
   input  logic [31:0] i_interval,
   output logic [31:0] o_compare,
   output logic [1:0]  o_control,
   output logic        o_busy,
   output logic        o_done
);

   localparam logic [1:0] CTRL_OFF = 2'b00;
   localparam logic [1:0] CTRL_PWM = 2'b10;

`ifdef PWM_RAMP_DOWN_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_HOLD = 2'd2,
      ST_DOWN = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_HOLD = 2'd2
   } state_t;
`endif

   state_t      r_state;
   logic [31:0] r_compare;
   logic [31:0] r_cnt;
   logic [1:0]  r_control;
   logic        r_busy;
   logic        r_done;

   // ---------------------------------------------------------------------
   // Update-point detection.
   // The >= comparison guards against interval being lowered below the
   // running count. In that case the counter would otherwise run all the
   // way round 2^32 before the next update.
   // ---------------------------------------------------------------------
   logic w_update;
   assign w_update = (r_cnt >= i_interval);

   // ---------------------------------------------------------------------
   // Ramp arithmetic toward target.
   // Upward: the sum is formed in 33 bits, so a carry out of bit 31 still
   //         compares greater than target and saturates to it.
   // Downward: the gap to target is compared against step before any
   //         subtraction, so compare - step never wraps below target.
   // ---------------------------------------------------------------------
   logic [32:0] w_sum;
   logic [31:0] w_gap;
   logic [31:0] w_up_val;
   logic [31:0] w_dn_val;
   logic [31:0] w_ramp_val;

   assign w_sum    = {1'b0, r_compare} + {1'b0, i_step};
   assign w_gap    = r_compare - i_target;
   assign w_up_val = (w_sum > {1'b0, i_target}) ? i_target : w_sum[31:0];
   assign w_dn_val = (w_gap <= i_step) ? i_target : (r_compare - i_step);

   always_comb begin
      w_ramp_val = r_compare;
      if (i_step == 32'd0) begin
         w_ramp_val = i_target;
      end else if (r_compare < i_target) begin
         w_ramp_val = w_up_val;
      end else if (r_compare > i_target) begin
         w_ramp_val = w_dn_val;
      end
   end

`ifdef PWM_RAMP_DOWN_EN
   // Soft release toward zero. A step of zero, or a step at least as large
   // as the remaining compare, lands exactly on 0.
   logic [31:0] w_down_val;
   assign w_down_val = ((i_step == 32'd0) || (i_step >= r_compare)) ? 32'd0
                                                                    : (r_compare - i_step);
`endif

   // ---------------------------------------------------------------------
   // Main FSM. State and every output register are updated together, so
   // control and busy always describe the state being entered.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_compare <= 32'd0;
         r_cnt     <= 32'd0;
         r_control <= CTRL_OFF;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         // done is a single-cycle pulse. Only the update that lands on
         // the target raises it again.
         r_done <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               r_compare <= 32'd0;
               r_cnt     <= 32'd0;
               if (i_enable) begin
                  r_state   <= ST_RAMP;
                  r_control <= CTRL_PWM;
                  r_busy    <= 1'b1;
               end else begin
                  r_control <= CTRL_OFF;
                  r_busy    <= 1'b0;
               end
            end

            ST_RAMP: begin
               if (!i_enable) begin
`ifdef PWM_RAMP_DOWN_EN
                  r_state   <= ST_DOWN;
                  r_cnt     <= 32'd0;
                  r_control <= CTRL_PWM;
                  r_busy    <= 1'b1;
`else
                  r_state   <= ST_IDLE;
                  r_compare <= 32'd0;
                  r_cnt     <= 32'd0;
                  r_control <= CTRL_OFF;
                  r_busy    <= 1'b0;
`endif
               end else if (w_update) begin
                  r_cnt     <= 32'd0;
                  r_compare <= w_ramp_val;
                  // Also covers entering RAMP already at target: the
                  // first update leaves compare unchanged and completes.
                  if (w_ramp_val == i_target) begin
                     r_state <= ST_HOLD;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end

            ST_HOLD: begin
               if (!i_enable) begin
`ifdef PWM_RAMP_DOWN_EN
                  r_state   <= ST_DOWN;
                  r_cnt     <= 32'd0;
                  r_control <= CTRL_PWM;
                  r_busy    <= 1'b1;
`else
                  r_state   <= ST_IDLE;
                  r_compare <= 32'd0;
                  r_cnt     <= 32'd0;
                  r_control <= CTRL_OFF;
                  r_busy    <= 1'b0;
`endif
               end else if (i_target != r_compare) begin
                  // Retarget: a fresh full interval elapses before the
                  // first step.
                  r_state <= ST_RAMP;
                  r_cnt   <= 32'd0;
                  r_busy  <= 1'b1;
               end
            end

`ifdef PWM_RAMP_DOWN_EN
            ST_DOWN: begin
               if (i_enable) begin
                  // Re-engage from wherever the soft release got to.
                  r_state <= ST_RAMP;
                  r_cnt   <= 32'd0;
                  r_busy  <= 1'b1;
               end else if (w_update) begin
                  r_cnt     <= 32'd0;
                  r_compare <= w_down_val;
                  if (w_down_val == 32'd0) begin
                     r_state   <= ST_IDLE;
                     r_control <= CTRL_OFF;
                     r_busy    <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
`endif

            default: begin
               r_state   <= ST_IDLE;
               r_compare <= 32'd0;
               r_cnt     <= 32'd0;
               r_control <= CTRL_OFF;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign o_compare = r_compare;
   assign o_control = r_control;
   assign o_busy    = r_busy;
   assign o_done    = r_done;

endmodule
